// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states and width constants.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 12;

  // Signed quotient limits at the default width.
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle of the sequential divider, same start/ready handshake as the Booth multiplier.
import div_pkg::*;

interface seq_divider_if #(parameter int WIDTH = DEF_WIDTH);
  // Handshake: start is taken only at a rising edge where ready=1; operands are sampled on that edge.
  // ready stays low while busy; quotient/remainder/ovf/dbz are valid and held whenever ready=1.
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 ready;
  logic                 ovf;
  logic                 dbz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, ovf, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, ovf, dbz
  );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit and trial-subtract the divisor magnitude.
module div_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // rem_in < dvs, so the shifted value fits WIDTH+1 bits and a successful difference fits WIDTH bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    borrow  = (shifted < {1'b0, dvs});
    diff    = shifted[WIDTH-1:0] - dvs;
    q_bit   = ~borrow;
    rem_out = borrow ? shifted[WIDTH-1:0] : diff;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: 2W/W restoring division on magnitudes, then a one-cycle sign fix-up.
// Build option DIV_SATURATE_EN: saturate the quotient on overflow / divide-by-zero instead of zeroing it.
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  seq_divider_if.slave        bus,
  output state_e              dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef DIV_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               sdvd_q, sdvd_d;
  logic               sdvs_q, sdvs_d;
  logic               ovf_i_q, ovf_i_d;
  logic               dbz_i_q, dbz_i_d;
  logic [WIDTH-1:0]   q_out_q, q_out_d;
  logic [WIDTH-1:0]   r_out_q, r_out_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               neg_q;
  logic               range_ovf;

  assign dvd_abs = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_abs = bus.divisor[WIDTH-1]    ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (lo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The magnitude quotient is below 2^WIDTH here; the negative side may reach one further than the positive.
  assign neg_q     = sdvd_q ^ sdvs_q;
  assign range_ovf = neg_q ? (quo_q > Q_MIN) : (quo_q > Q_MAX);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    sdvd_d  = sdvd_q;
    sdvs_d  = sdvs_q;
    ovf_i_d = ovf_i_q;
    dbz_i_d = dbz_i_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = dvd_abs[2*WIDTH-1:WIDTH];
          lo_d    = dvd_abs[WIDTH-1:0];
          dvs_d   = dvs_abs;
          quo_d   = '0;
          sdvd_d  = bus.dividend[2*WIDTH-1];
          sdvs_d  = bus.divisor[WIDTH-1];
          ovf_i_d = 1'b0;
          dbz_i_d = 1'b0;
          count_d = CNT_W'(WIDTH);
          if (bus.divisor == '0) begin
            dbz_i_d = 1'b1;
            state_d = FIX;
          end else if (dvd_abs[2*WIDTH-1:WIDTH] >= dvs_abs) begin
            ovf_i_d = 1'b1;
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d   = step_rem;
        quo_d   = {quo_q[WIDTH-2:0], step_q};
        lo_d    = {lo_q[WIDTH-2:0], 1'b0};
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        if (dbz_i_q) begin
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          q_out_d = SAT_EN ? (sdvd_q ? Q_MIN : Q_MAX) : '0;
          r_out_d = '0;
        end else if (ovf_i_q || range_ovf) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b1;
          q_out_d = SAT_EN ? (neg_q ? Q_MIN : Q_MAX) : '0;
          r_out_d = '0;
        end else begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          q_out_d = neg_q  ? -quo_q : quo_q;
          r_out_d = sdvd_q ? -rem_q : rem_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      sdvd_q  <= 1'b0;
      sdvs_q  <= 1'b0;
      ovf_i_q <= 1'b0;
      dbz_i_q <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      sdvd_q  <= sdvd_d;
      sdvs_q  <= sdvs_d;
      ovf_i_q <= ovf_i_d;
      dbz_i_q <= dbz_i_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.quotient  = q_out_q;
  assign bus.remainder = r_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, start-ignore, reset abort, back-to-back and random operands vs an arithmetic model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 12;
`ifdef DIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dbz;
    int           lat;
  } res_t;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Reference: plain signed arithmetic; '/' truncates toward zero and '%' follows the dividend sign.
  function automatic res_t model(input longint a, input longint b);
    res_t   e;
    longint qq, rr, aa, bb;
    aa = (a < 0) ? -a : a;
    bb = (b < 0) ? -b : b;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.lat = W + 1;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.lat = 1;
      e.r   = '0;
      e.q   = SAT ? ((a < 0) ? 12'h800 : 12'h7FF) : 12'h000;
    end else begin
      qq = a / b;
      rr = a % b;
      if (aa >= bb * 4096) e.lat = 1;
      if (qq > 2047 || qq < -2048) begin
        e.ovf = 1'b1;
        e.q   = SAT ? ((qq > 0) ? 12'h7FF : 12'h800) : 12'h000;
        e.r   = '0;
      end else begin
        e.q = qq[W-1:0];
        e.r = rr[W-1:0];
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Counts negedges with ready low after the accepting edge, then samples the held results.
  task automatic collect(output res_t g, output bit to);
    g.lat = 0;
    to    = 1'b0;
    @(negedge clk);
    while (!bus.ready) begin
      g.lat++;
      if (g.lat > 100) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
    end
    g.q   = bus.quotient;
    g.r   = bus.remainder;
    g.ovf = bus.ovf;
    g.dbz = bus.dbz;
  endtask

  task automatic do_op(input longint a, input longint b, output res_t g, output bit to);
    wait_idle();
    @(negedge clk);
    bus.dividend = a[2*W-1:0];
    bus.divisor  = b[W-1:0];
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    collect(g, to);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.quotient !== '0 || bus.remainder !== '0 ||
        bus.ovf !== 1'b0 || bus.dbz !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset: ready=%b q=%h r=%h ovf=%b dbz=%b st=%0d, required ready=1 q=0 r=0 ovf=0 dbz=0 IDLE",
               bus.ready, bus.quotient, bus.remainder, bus.ovf, bus.dbz, dbg_state);
    end
  endtask

  task automatic test_directed();
    longint ta[12] = '{1000, -1000, 1000, 5, 14336, -14336, 1048576, -8388608, -8388608, 8388607, -7, 4190209};
    longint tb[12] = '{7, 7, -7, 0, 7, 7, 3, 1, -2048, 2047, 2, 2047};
    res_t g, e;
    bit   to;
    for (int i = 0; i < 12; i++) begin
      e = model(ta[i], tb[i]);
      do_op(ta[i], tb[i], g, to);
      checks++;
      if (to || g.q !== e.q || g.r !== e.r || g.ovf !== e.ovf || g.dbz !== e.dbz || g.lat != e.lat) begin
        errors++;
        $display("FAIL directed %0d/%0d: q=%h r=%h ovf=%b dbz=%b lat=%0d to=%b, required q=%h r=%h ovf=%b dbz=%b lat=%0d",
                 ta[i], tb[i], g.q, g.r, g.ovf, g.dbz, g.lat, to, e.q, e.r, e.ovf, e.dbz, e.lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    res_t g;
    bit   to;
    wait_idle();
    @(negedge clk);
    bus.dividend = 24'd1000;
    bus.divisor  = 12'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.dividend = 24'd5000;
    bus.divisor  = -12'sd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    collect(g, to);
    g.lat = g.lat + 3;
    checks++;
    if (to || g.q !== 12'd142 || g.r !== 12'd6 || g.ovf !== 1'b0 || g.dbz !== 1'b0 || g.lat != 13) begin
      errors++;
      $display("FAIL ignore_start: q=%h r=%h ovf=%b dbz=%b lat=%0d to=%b, required q=08e r=006 ovf=0 dbz=0 lat=13",
               g.q, g.r, g.ovf, g.dbz, g.lat, to);
    end
  endtask

  task automatic test_abort();
    wait_idle();
    @(negedge clk);
    bus.dividend = 24'd1000;
    bus.divisor  = 12'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus.ready !== 1'b1 || bus.quotient !== '0 || bus.remainder !== '0 ||
        bus.ovf !== 1'b0 || bus.dbz !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL abort: ready=%b q=%h r=%h ovf=%b dbz=%b st=%0d, required ready=1 q=0 r=0 ovf=0 dbz=0 IDLE",
               bus.ready, bus.quotient, bus.remainder, bus.ovf, bus.dbz, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    res_t g, e;
    bit   to;
    wait_idle();
    @(negedge clk);
    bus.dividend = 24'd1000;
    bus.divisor  = 12'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.dividend = -24'sd1000;
    bus.divisor  = 12'd7;
    collect(g, to);
    checks++;
    if (to || g.q !== 12'h08E || g.r !== 12'h006 || g.lat != 13) begin
      errors++;
      $display("FAIL back_to_back first: q=%h r=%h lat=%0d to=%b, required q=08e r=006 lat=13", g.q, g.r, g.lat, to);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    e = model(-1000, 7);
    collect(g, to);
    checks++;
    if (to || g.q !== e.q || g.r !== e.r || g.ovf !== e.ovf || g.lat != e.lat) begin
      errors++;
      $display("FAIL back_to_back second: q=%h r=%h ovf=%b lat=%0d to=%b, required q=%h r=%h ovf=%b lat=%0d",
               g.q, g.r, g.ovf, g.lat, to, e.q, e.r, e.ovf, e.lat);
    end
  endtask

  task automatic test_random();
    longint ex_a[4] = '{-8388608, 8388607, -1, 0};
    longint ex_b[4] = '{-2048, 2047, -1, 1};
    res_t   g, e;
    bit     to;
    longint a, b, bm;
    int     mode;
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 9);
      b = longint'($signed(12'($urandom)));
      if (b == 0) b = 1;
      bm = (b < 0) ? -b : b;
      if (mode == 0) begin
        a = longint'($signed(24'($urandom)));
        b = 0;
      end else if (mode == 1) begin
        a = longint'($signed(24'($urandom)));
      end else if (mode == 9) begin
        a = ex_a[$urandom_range(0, 3)];
        b = ex_b[$urandom_range(0, 3)];
      end else begin
        a = longint'($urandom_range(0, 8388607)) % (bm * 4096);
        if ($urandom_range(0, 1) == 1) a = -a;
      end
      e = model(a, b);
      do_op(a, b, g, to);
      checks++;
      if (to || g.q !== e.q || g.r !== e.r || g.ovf !== e.ovf || g.dbz !== e.dbz || g.lat != e.lat) begin
        errors++;
        $display("FAIL random %0d/%0d: q=%h r=%h ovf=%b dbz=%b lat=%0d to=%b, required q=%h r=%h ovf=%b dbz=%b lat=%0d",
                 a, b, g.q, g.r, g.ovf, g.dbz, g.lat, to, e.q, e.r, e.ovf, e.dbz, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed integer divider; the inverse companion to the team's radix-4 Booth multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Uses the same start/ready handshake as the multiplier, so the datapath controller drives both units identically.
- Radix-2 restoring algorithm on magnitudes, with a sign fix-up step at the end.

Parameters:
WIDTH, 12, divisor/quotient/remainder width; dividend is 2*WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when ready=1
dividend  input  2*WIDTH  signed two's-complement; sampled on the accepting edge
divisor  input  WIDTH  signed two's-complement; sampled on the accepting edge
quotient  output  WIDTH  signed result, truncated toward zero
remainder  output  WIDTH  signed; sign follows the dividend
ready  output  1  1 = idle and results valid/held
ovf  output  1  quotient not representable in WIDTH signed bits
dbz  output  1  divide by zero

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, ready=1, quotient=0, remainder=0, ovf=0, dbz=0. rst has priority over start.
- States: IDLE, CALC, FIX. ready=1 only in IDLE. ready is registered state, not derived combinationally from start.
- IDLE:
  - start=1 at an edge accepts the operands.
  - Latch |dividend| (2*WIDTH-bit unsigned, so -2^(2W-1) is handled), |divisor| (WIDTH-bit unsigned) and both sign bits.
  - Clear ovf and dbz.
  - divisor==0 -> set the dbz flag and go to FIX.
  - Otherwise, if |dividend|[2W-1:W] >= |divisor| -> set the internal ovf flag and go to FIX.
  - Otherwise -> go to CALC with count=WIDTH.
- CALC:
  - One restoring step per cycle: shift the partial remainder left by 1, bring in the next dividend bit, trial-subtract |divisor|.
  - Quotient bit = no borrow; restore on borrow.
  - count decrements each cycle; at count==1 go to FIX.
  - start is ignored while busy.
- FIX (1 cycle):
  - Negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Signed range check: positive result > 2^(W-1)-1, or negative result magnitude > 2^(W-1), sets ovf.
  - Register all outputs, go to IDLE.
- On ovf or dbz: quotient=0 and remainder=0, unless DIV_SATURATE_EN is defined (see below).
- Latency: after the accepting edge, ready is low for WIDTH+1 cycles (13 at the default WIDTH) on the normal and signed-overflow paths, and for 1 cycle on the dbz/pre-check overflow paths.
- Outputs hold their values until the next accepted start; they update only on the FIX edge.
- start held high continuously: a new operation is accepted on the first edge with ready=1.

Optional Feature:
- Macro: DIV_SATURATE_EN.
- Defined: on ovf, quotient saturates to 2^(W-1)-1 if the true result is positive, or to -2^(W-1) if negative; remainder=0.
- Defined: on dbz, quotient saturates by the dividend sign (non-negative dividend -> max, negative -> min); remainder=0.
- Undefined: quotient=0 and remainder=0 on both ovf and dbz.
- Flags behave identically either way.

Decomposition:
- Package div_pkg: state enumeration (IDLE/CALC/FIX), default WIDTH constant, saturation constants derived from WIDTH.
- One combinational sub-module, div_step: inputs partial remainder, next dividend bit and |divisor|; outputs the new partial remainder and the quotient bit. It is instantiated once in CALC.

Test Plan:
- 1000 / 7 -> quotient=142 (0x08E), remainder=6, ovf=0, dbz=0; ready low exactly 13 cycles.
- -1000 / 7 -> quotient=0xF72 (-142), remainder=0xFFA (-6). 1000 / -7 -> quotient=0xF72, remainder=6.
- divisor=0, dividend=5 -> dbz=1, quotient=0, remainder=0, ready low 1 cycle; with DIV_SATURATE_EN, quotient=0x7FF.
- 14336 / 7 -> ovf=1, quotient=0 (0x7FF with DIV_SATURATE_EN); -14336 / 7 -> quotient=0x800, remainder=0, ovf=0.
- Pre-check overflow: 2^20 / 3 -> ovf=1, ready low 1 cycle.
- Start 1000/7; pulse rst on cycle 5 -> ready=1 and all outputs 0 after that edge. Assert start with new operands on cycle 3 without rst -> ignored; the first result (142, 6) completes unchanged.
